// File: rtl/branch_predictor_table_pkg.sv
// Shared definitions for the branch predictor table: default sizing,
// outcome/prediction encodings and counter reset/allocate helpers.
package branch_predictor_table_pkg;

  localparam int BP_ENTRIES   = 64;
  localparam int BP_CTR_WIDTH = 2;
  localparam int BP_GHR_WIDTH = 0;

  typedef enum logic [1:0] {
    STRONG_NOT_TAKEN = 2'b00,
    WEAK_NOT_TAKEN   = 2'b01,
    WEAK_TAKEN       = 2'b10,
    STRONG_TAKEN     = 2'b11
  } branch_state_e;

  typedef enum logic {
    PREDICT_NOT_TAKEN = 1'b0,
    PREDICT_TAKEN     = 1'b1
  } predict_taken_e;

  typedef enum logic {
    BRANCH_NOT_TAKEN = 1'b0,
    BRANCH_TAKEN     = 1'b1
  } branch_taken_e;

  // Weakly taken: MSB set, lower bits clear (width-1 counter gives 1).
  function automatic logic [3:0] ctr_weak_taken(input int width);
    return 4'(1 << (width - 1));
  endfunction

  // Weakly not-taken: MSB clear, lower bits set (width-1 counter gives 0).
  function automatic logic [3:0] ctr_weak_not_taken(input int width);
    return 4'((1 << (width - 1)) - 1);
  endfunction

endpackage

// File: rtl/branch_predictor_table_sat_counter.sv
// Next-state logic for a saturating up/down counter; a 1-bit counter
// degenerates to "last outcome".
module sat_counter #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_taken,
  output logic [WIDTH-1:0] o_next
);

  localparam logic [WIDTH-1:0] C_MAX = '1;

  if (WIDTH == 1) begin : g_last_outcome
    assign o_next = i_taken;
  end else begin : g_saturating
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
      o_next = i_count;
      if (i_taken) begin
        if (i_count != C_MAX) o_next = i_count + WIDTH'(1);
      end else begin
        if (i_count != '0) o_next = i_count - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/branch_predictor_table.sv
// Direct-mapped branch target / direction table with combinational lookup,
// bimodal or gshare indexing and non-speculative global history.
module branch_predictor_table
  import branch_predictor_table_pkg::*;
#(
  parameter int ENTRIES   = BP_ENTRIES,
  parameter int CTR_WIDTH = BP_CTR_WIDTH,
  parameter int GHR_WIDTH = BP_GHR_WIDTH
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [31:0]                IF_PC,
  output logic                       Predict_Taken,
  output logic [31:0]                Predict_Target,
  output logic [$clog2(ENTRIES)-1:0] Predict_Index,
  input  logic                       Update_En,
  input  logic [31:0]                Update_PC,
  input  logic [$clog2(ENTRIES)-1:0] Update_Index,
  input  logic                       Update_Taken,
  input  logic [31:0]                Update_Target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  localparam logic [CTR_WIDTH-1:0] C_WEAK_T  = CTR_WIDTH'(ctr_weak_taken(CTR_WIDTH));
  localparam logic [CTR_WIDTH-1:0] C_WEAK_NT = CTR_WIDTH'(ctr_weak_not_taken(CTR_WIDTH));

  if (ENTRIES < 2 || ENTRIES > 1024 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
    $fatal(1, "branch_predictor_table: ENTRIES=%0d must be a power of two in 2..1024", ENTRIES);
  end
  if (CTR_WIDTH < 1 || CTR_WIDTH > 4) begin : g_bad_ctr
    $fatal(1, "branch_predictor_table: CTR_WIDTH=%0d must be in 1..4", CTR_WIDTH);
  end
  if (GHR_WIDTH < 0 || GHR_WIDTH > IDX_W) begin : g_bad_ghr
    $fatal(1, "branch_predictor_table: GHR_WIDTH=%0d must be in 0..%0d", GHR_WIDTH, IDX_W);
  end

  logic                 r_valid  [ENTRIES];
  logic [TAG_W-1:0]     r_tag    [ENTRIES];
  logic [31:0]          r_target [ENTRIES];
  logic [CTR_WIDTH-1:0] r_ctr    [ENTRIES];

  logic [IDX_W-1:0]     w_ghr_ext;
  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_if_tag;
  logic                 w_hit;
  logic                 w_taken;
  logic [TAG_W-1:0]     w_upd_tag;
  logic                 w_upd_hit;
  logic [CTR_WIDTH-1:0] w_ctr_next;
  logic                 w_unused_bits;

  assign w_unused_bits = ^{IF_PC[1:0], Update_PC[1:0]};

  // Global history only moves on resolved branches, so it never needs repair.
  if (GHR_WIDTH > 0) begin : g_gshare
    logic [GHR_WIDTH-1:0] r_ghr;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_ghr <= '0;
      end else if (Update_En) begin
        r_ghr <= GHR_WIDTH'({r_ghr, Update_Taken});
      end
    end

    assign w_ghr_ext = IDX_W'(r_ghr);
  end else begin : g_bimodal
    assign w_ghr_ext = '0;
  end

  assign w_idx    = IF_PC[IDX_W+1:2] ^ w_ghr_ext;
  assign w_if_tag = IF_PC[31:IDX_W+2];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_if_tag);
  assign w_taken  = w_hit && r_ctr[w_idx][CTR_WIDTH-1];

  // Lookup reads the registered table only: a same-cycle update is not bypassed.
  assign Predict_Taken  = w_taken ? PREDICT_TAKEN : PREDICT_NOT_TAKEN;
  assign Predict_Target = w_taken ? r_target[w_idx] : IF_PC + 32'd4;
  assign Predict_Index  = w_idx;

  assign w_upd_tag = Update_PC[31:IDX_W+2];
  assign w_upd_hit = r_valid[Update_Index] && (r_tag[Update_Index] == w_upd_tag);

  sat_counter #(
    .WIDTH (CTR_WIDTH)
  ) u_sat_counter (
    .i_count (r_ctr[Update_Index]),
    .i_taken (Update_Taken),
    .o_next  (w_ctr_next)
  );

  // NOTE: the table is plain flops, so every entry is cleared by the async reset;
  // sequential state is written only with non-blocking assignments.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= C_WEAK_NT;
      end
    end else if (Update_En) begin
      if (w_upd_hit) begin
        r_ctr[Update_Index] <= w_ctr_next;
        if (Update_Taken == BRANCH_TAKEN) r_target[Update_Index] <= Update_Target;
      end else if (Update_Taken == BRANCH_TAKEN) begin
        r_valid[Update_Index]  <= 1'b1;
        r_tag[Update_Index]    <= w_upd_tag;
        r_target[Update_Index] <= Update_Target;
        r_ctr[Update_Index]    <= C_WEAK_T;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed bench: a default bimodal instance and a 4-bit gshare,
// 1-bit-counter instance sharing the lookup/update buses.
module tb_branch_predictor_table;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        upd_en;
  logic        upd_en_gs;
  logic [31:0] upd_pc;
  logic [5:0]  upd_idx;
  logic [5:0]  upd_idx_gs;
  logic        upd_taken;
  logic [31:0] upd_target;

  logic        bm_taken;
  logic [31:0] bm_target;
  logic [5:0]  bm_index;
  logic        gs_taken;
  logic [31:0] gs_target;
  logic [5:0]  gs_index;

  logic [3:0]  ghr_m;
  int          n_cmp;
  int          n_bad;

  branch_predictor_table dut (
    .CLK            (clk),
    .RST_N          (rst_n),
    .IF_PC          (if_pc),
    .Predict_Taken  (bm_taken),
    .Predict_Target (bm_target),
    .Predict_Index  (bm_index),
    .Update_En      (upd_en),
    .Update_PC      (upd_pc),
    .Update_Index   (upd_idx),
    .Update_Taken   (upd_taken),
    .Update_Target  (upd_target)
  );

  branch_predictor_table #(
    .ENTRIES   (64),
    .CTR_WIDTH (1),
    .GHR_WIDTH (4)
  ) dut_gs (
    .CLK            (clk),
    .RST_N          (rst_n),
    .IF_PC          (if_pc),
    .Predict_Taken  (gs_taken),
    .Predict_Target (gs_target),
    .Predict_Index  (gs_index),
    .Update_En      (upd_en_gs),
    .Update_PC      (upd_pc),
    .Update_Index   (upd_idx_gs),
    .Update_Taken   (upd_taken),
    .Update_Target  (upd_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic look_bm(input string tag, input logic [31:0] pc,
                         input logic exp_tk, input logic [31:0] exp_tgt);
    logic [31:0] idx;
    idx   = {26'd0, pc[7:2]};
    if_pc = pc;
    #1;
    check({tag, "_taken"}, {31'd0, bm_taken}, {31'd0, exp_tk});
    check({tag, "_target"}, bm_target, exp_tgt);
    check({tag, "_index"}, {26'd0, bm_index}, idx);
  endtask

  task automatic look_gs(input string tag, input logic [31:0] pc, input logic [5:0] exp_idx,
                         input logic exp_tk, input logic [31:0] exp_tgt);
    if_pc = pc;
    #1;
    check({tag, "_index"}, {26'd0, gs_index}, {26'd0, exp_idx});
    check({tag, "_taken"}, {31'd0, gs_taken}, {31'd0, exp_tk});
    check({tag, "_target"}, gs_target, exp_tgt);
  endtask

  task automatic upd_bm(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    @(negedge clk);
    upd_en     = 1'b1;
    upd_pc     = pc;
    upd_idx    = pc[7:2];
    upd_taken  = tk;
    upd_target = tgt;
    @(negedge clk);
    upd_en     = 1'b0;
  endtask

  task automatic upd_gs(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    @(negedge clk);
    upd_en_gs  = 1'b1;
    upd_pc     = pc;
    upd_idx_gs = pc[7:2] ^ {2'b00, ghr_m};
    upd_taken  = tk;
    upd_target = tgt;
    @(negedge clk);
    upd_en_gs  = 1'b0;
    ghr_m      = {ghr_m[2:0], tk};
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    ghr_m      = 4'd0;
    rst_n      = 1'b0;
    if_pc      = 32'h100;
    upd_en     = 1'b0;
    upd_en_gs  = 1'b0;
    upd_pc     = 32'h0;
    upd_idx    = 6'd0;
    upd_idx_gs = 6'd0;
    upd_taken  = 1'b0;
    upd_target = 32'h0;

    // Outputs while held in reset.
    look_bm("rst_hold", 32'h100, 1'b0, 32'h104);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold lookup, then allocate with weakly taken.
    look_bm("cold", 32'h100, 1'b0, 32'h104);
    upd_bm(32'h100, 1'b1, 32'h80);
    look_bm("alloc", 32'h100, 1'b1, 32'h80);

    // Not-taken miss on same index leaves the entry alone.
    upd_bm(32'h200, 1'b0, 32'h999);
    look_bm("nt_miss_other", 32'h200, 1'b0, 32'h204);
    look_bm("nt_miss_keep", 32'h100, 1'b1, 32'h80);

    // 10 -> 11 -> 11 (saturate), then 10 still taken, 01 not taken.
    upd_bm(32'h100, 1'b1, 32'h80);
    upd_bm(32'h100, 1'b1, 32'h80);
    upd_bm(32'h100, 1'b0, 32'h0);
    look_bm("sat_hi_n1", 32'h100, 1'b1, 32'h80);
    upd_bm(32'h100, 1'b0, 32'h0);
    look_bm("sat_hi_n2", 32'h100, 1'b0, 32'h104);

    // 01 -> 10 with a new target on a taken hit.
    upd_bm(32'h100, 1'b1, 32'h90);
    look_bm("retarget", 32'h100, 1'b1, 32'h90);

    // Conflicting tag at index 0 evicts 0x100.
    look_bm("conflict_miss", 32'h200, 1'b0, 32'h204);
    upd_bm(32'h200, 1'b1, 32'h40);
    look_bm("evict_new", 32'h200, 1'b1, 32'h40);
    look_bm("evict_old", 32'h100, 1'b0, 32'h104);

    // Same-cycle lookup and update: lookup sees pre-update contents.
    @(negedge clk);
    if_pc      = 32'h200;
    upd_en     = 1'b1;
    upd_pc     = 32'h200;
    upd_idx    = 6'd0;
    upd_taken  = 1'b0;
    upd_target = 32'h0;
    #1;
    check("nobypass_taken", {31'd0, bm_taken}, 32'd1);
    check("nobypass_target", bm_target, 32'h40);
    @(negedge clk);
    upd_en = 1'b0;
    look_bm("after_same", 32'h200, 1'b0, 32'h204);

    // 01 -> 00 -> 00 (saturate), then 01 not taken, 10 taken.
    upd_bm(32'h200, 1'b0, 32'h0);
    upd_bm(32'h200, 1'b0, 32'h0);
    upd_bm(32'h200, 1'b1, 32'h40);
    look_bm("sat_lo_t1", 32'h200, 1'b0, 32'h204);
    upd_bm(32'h200, 1'b1, 32'h44);
    look_bm("sat_lo_t2", 32'h200, 1'b1, 32'h44);

    // A second entry at index 13.
    upd_bm(32'h1234, 1'b1, 32'hABC0);
    look_bm("idx13", 32'h1234, 1'b1, 32'hABC0);

    // Gshare: T,T,N,T gives history 4'b1101.
    look_gs("gs_cold", 32'h100, 6'h00, 1'b0, 32'h104);
    upd_gs(32'h100, 1'b1, 32'h80);
    upd_gs(32'h100, 1'b1, 32'h80);
    upd_gs(32'h100, 1'b0, 32'h0);
    upd_gs(32'h100, 1'b1, 32'h80);
    look_gs("gs_hist", 32'h100, 6'h0D, 1'b0, 32'h104);

    // Allocate entry 13 (history becomes 1011), then reach it via 0x118.
    upd_gs(32'h100, 1'b1, 32'h80);
    look_gs("gs_alloc", 32'h118, 6'h0D, 1'b1, 32'h80);

    // 1-bit counter follows the last outcome (history 0110, then 1101).
    upd_gs(32'h118, 1'b0, 32'h0);
    look_gs("gs_last_nt", 32'h12C, 6'h0D, 1'b0, 32'h130);
    upd_gs(32'h12C, 1'b1, 32'h55C);
    look_gs("gs_last_t", 32'h100, 6'h0D, 1'b1, 32'h55C);

    // Asynchronous reset mid-cycle, concurrent with updates on both instances.
    @(negedge clk);
    upd_en     = 1'b1;
    upd_en_gs  = 1'b1;
    upd_pc     = 32'h1234;
    upd_idx    = 6'h0D;
    upd_idx_gs = 6'h0D;
    upd_taken  = 1'b1;
    upd_target = 32'h777;
    #2;
    rst_n = 1'b0;
    look_bm("arst_e13", 32'h1234, 1'b0, 32'h1238);
    look_bm("arst_e0", 32'h200, 1'b0, 32'h204);
    look_gs("arst_gs", 32'h100, 6'h00, 1'b0, 32'h104);
    @(negedge clk);
    upd_en    = 1'b0;
    upd_en_gs = 1'b0;
    rst_n     = 1'b1;
    ghr_m     = 4'd0;
    look_bm("post_rst_e13", 32'h1234, 1'b0, 32'h1238);
    look_gs("post_rst_gs", 32'h100, 6'h00, 1'b0, 32'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
